psram_qspi_responder: RTL and testbench

Synthesizable QSPI PSRAM device model: the memory-side responder for the QPI PSRAM controller, used in simulation and FPGA smoke tests as the PSRAM chip behind the SoC. It oversamples the serial pins with its own clock, starts in SPI mode, enters QPI on command 35h, and serves quad read (EBh) and quad write (38h) from an internal byte array. Status outputs expose the mode and protocol errors to the bench.

---
 rtl/psram_qspi_responder.sv | 188 ++++++++++++++++++
 tb/tb_psram_qspi_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/psram_qspi_responder.sv
// QSPI PSRAM device model: oversamples sck/ce_n/din on clk_i, boots in SPI mode,
// switches to QPI on 35h and serves quad read (EBh) / quad write (38h) from a byte array.
module psram_qspi_responder #(
    parameter int ADDR_W = 12,
    parameter int DUMMY  = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic [3:0] douten,
    output logic       qpi_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    localparam logic [3:0] LAST_DUMMY = 4'(DUMMY - 1);

    logic [2:0] sck_sync;
    logic [1:0] ce_sync;
    logic [3:0] din_s1, din_s2;
    logic       ce_s, rise, fall;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              is_read_q, is_read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              half_q, half_d;
    logic [3:0]        wnib_q, wnib_d;
    logic              qpi_d, err_d;
    logic [3:0]        dout_d, douten_d;
    logic              mem_we;
    logic [7:0]        rd_byte;

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync <= '0;
            ce_sync  <= 2'b11;
            din_s1   <= '0;
            din_s2   <= '0;
        end else begin
            sck_sync <= {sck_sync[1:0], sck};
            ce_sync  <= {ce_sync[0], ce_n};
            din_s1   <= din;
            din_s2   <= din_s1;
        end
    end

    assign ce_s    = ce_sync[1];
    assign rise    = sck_sync[1] & ~sck_sync[2];
    assign fall    = ~sck_sync[1] & sck_sync[2];
    assign rd_byte = mem[addr_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        half_d    = half_q;
        wnib_d    = wnib_q;
        qpi_d     = qpi_o;
        err_d     = 1'b0;
        dout_d    = dout;
        douten_d  = douten;
        mem_we    = 1'b0;

        // Deselect has priority over any strobe seen in the same cycle.
        if (ce_s) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            half_d   = 1'b0;
            douten_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                end
                S_CMD: if (rise) begin
                    cnt_d = cnt_q + 4'd1;
                    if (!qpi_o) begin
                        cmd_d = {cmd_q[6:0], din_s2[0]};
                        if (cnt_q == 4'd7) begin
                            state_d = S_IGNORE;
                            if (cmd_d == 8'h35) qpi_d = 1'b1;
                            else                err_d = 1'b1;
                        end
                    end else begin
                        cmd_d = {cmd_q[3:0], din_s2};
                        if (cnt_q == 4'd1) begin
                            cnt_d     = '0;
                            is_read_d = (cmd_d == 8'hEB);
                            unique case (cmd_d)
                                8'hEB, 8'h38: state_d = S_ADDR;
                                8'hF5: begin
                                    qpi_d   = 1'b0;
                                    state_d = S_IGNORE;
                                end
                                8'h35: state_d = S_IGNORE;
                                default: begin
                                    err_d   = 1'b1;
                                    state_d = S_IGNORE;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: if (rise) begin
                    // Only the low ADDR_W bits of the 24-bit address survive the shift.
                    addr_d = {addr_q[ADDR_W-5:0], din_s2};
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd5) begin
                        cnt_d   = '0;
                        half_d  = 1'b0;
                        state_d = is_read_q ? S_DUMMY : S_WDATA;
                    end
                end
                S_DUMMY: if (rise) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_DUMMY) begin
                        cnt_d   = '0;
                        state_d = S_RDATA;
                    end
                end
                S_RDATA: if (fall) begin
                    douten_d = 4'hF;
                    dout_d   = half_q ? rd_byte[3:0] : rd_byte[7:4];
                    half_d   = ~half_q;
                    if (half_q) addr_d = addr_q + 1'b1;
                end
                S_WDATA: if (rise) begin
                    if (!half_q) begin
                        wnib_d = din_s2;
                        half_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        half_d = 1'b0;
                        addr_d = addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            half_q    <= 1'b0;
            wnib_q    <= '0;
            qpi_o     <= 1'b0;
            err_o     <= 1'b0;
            dout      <= '0;
            douten    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            half_q    <= half_d;
            wnib_q    <= wnib_d;
            qpi_o     <= qpi_d;
            err_o     <= err_d;
            dout      <= dout_d;
            douten    <= douten_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; contents start undefined.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[addr_q] <= {wnib_q, din_s2};
    end

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Directed bench for psram_qspi_responder: host-side tasks drive SPI/QPI transactions,
// expected read nibbles go into a queue that a monitor drains on each host sampling rise.
module tb_psram_qspi_responder;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       sck = 1'b0;
    logic       ce_n = 1'b1;
    logic [3:0] din = '0;
    logic [3:0] dout, douten;
    logic       qpi_o, err_o;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int viol = 0;
    logic rd_window = 1'b0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    psram_qspi_responder #(.ADDR_W(12), .DUMMY(6)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .sck   (sck),
        .ce_n  (ce_n),
        .din   (din),
        .dout  (dout),
        .douten(douten),
        .qpi_o (qpi_o),
        .err_o (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Host samples read data on its own sck rise.
    initial forever begin
        @(posedge sck);
        if (douten == 4'hF) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_extra: got %0h with no expected nibble", dout);
            end else begin
                mon_exp = exp_q.pop_front();
                total--;
                check("rd_nib", {28'd0, dout}, {28'd0, mon_exp});
            end
        end
    end

    always @(negedge clk) begin
        if (err_o) err_cnt++;
        if (!rd_window && douten != 4'h0) viol++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_nib(input logic [3:0] n);
        din = n;
        wait_clk(6);
        sck = 1'b1;
        wait_clk(6);
        sck = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        ce_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        wait_clk(6);
        ce_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic spi_cmd(input logic [7:0] b);
        cs_low();
        for (int i = 7; i >= 0; i--) clock_nib({3'b000, b[i]});
        cs_high();
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        clock_nib(cmd[7:4]);
        clock_nib(cmd[3:0]);
        for (int j = 0; j < 6; j++) clock_nib(a[23-4*j -: 4]);
    endtask

    // Writes nbytes bytes taken MSB-first from data; extra >= 0 appends one stray nibble.
    task automatic qpi_write(input logic [23:0] a, input logic [31:0] data, input int nbytes,
                             input int extra);
        cs_low();
        send_hdr(8'h38, a);
        for (int i = 0; i < nbytes; i++) begin
            clock_nib(data[31-8*i -: 4]);
            clock_nib(data[27-8*i -: 4]);
        end
        if (extra >= 0) clock_nib(4'(extra));
        cs_high();
    endtask

    task automatic qpi_read(input logic [23:0] a, input logic [31:0] data, input int nbytes);
        cs_low();
        send_hdr(8'hEB, a);
        for (int j = 0; j < 6; j++) clock_nib(4'h0);
        rd_window = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            exp_q.push_back(data[31-8*i -: 4]);
            exp_q.push_back(data[27-8*i -: 4]);
        end
        for (int i = 0; i < 2 * nbytes; i++) clock_nib(4'h0);
        check("rd_all_seen", exp_q.size(), 0);
        exp_q.delete();
        cs_high();
        rd_window = 1'b0;
    endtask

    int err_before;

    initial begin
        wait_clk(3);
        check("rst_dout", {28'd0, dout}, 0);
        check("rst_douten", {28'd0, douten}, 0);
        check("rst_qpi", {31'd0, qpi_o}, 0);
        check("rst_err", {31'd0, err_o}, 0);
        rst_i = 1'b0;
        wait_clk(5);

        spi_cmd(8'h35);
        check("spi35_qpi", {31'd0, qpi_o}, 1);
        check("spi35_err", err_cnt, 0);

        qpi_write(24'h000010, 32'h11223344, 4, -1);
        qpi_read(24'h000010, 32'h11223344, 4);

        qpi_write(24'h000FFF, 32'hAABB0000, 2, -1);
        qpi_read(24'h000000, 32'hBB000000, 1);
        qpi_read(24'h000FFF, 32'hAABB0000, 2);

        qpi_write(24'h000021, 32'hC3000000, 1, -1);
        qpi_write(24'h000020, 32'h5A000000, 1, 6);
        qpi_read(24'h000020, 32'h5AC30000, 2);

        err_before = err_cnt;
        cs_low();
        clock_nib(4'h9);
        clock_nib(4'hF);
        for (int i = 0; i < 4; i++) clock_nib(4'h0);
        cs_high();
        check("err_pulse_cycles", err_cnt - err_before, 1);
        check("err_keeps_qpi", {31'd0, qpi_o}, 1);
        qpi_read(24'h000011, 32'h22000000, 1);

        cs_low();
        clock_nib(4'hF);
        clock_nib(4'h5);
        cs_high();
        check("f5_qpi", {31'd0, qpi_o}, 0);
        spi_cmd(8'h35);
        check("reenter_qpi", {31'd0, qpi_o}, 1);

        // Reset asserted while the read is actively driving.
        cs_low();
        send_hdr(8'hEB, 24'h000010);
        for (int j = 0; j < 6; j++) clock_nib(4'h0);
        rd_window = 1'b1;
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h1);
        clock_nib(4'h0);
        clock_nib(4'h0);
        wait_clk(5);
        check("pre_rst_douten", {28'd0, douten}, 32'hF);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("midrst_douten", {28'd0, douten}, 0);
        check("midrst_qpi", {31'd0, qpi_o}, 0);
        check("midrst_q_empty", exp_q.size(), 0);
        exp_q.delete();
        ce_n = 1'b1;
        wait_clk(5);
        rst_i = 1'b0;
        wait_clk(5);
        rd_window = 1'b0;
        wait_clk(5);

        check("douten_outside_reads", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
